dmem_arbiter: RTL

Two-port arbiter between the two SINGLE_CYCLE_CPU cores and the single-port shared data memory. It sits directly upstream of DATA_MEMORY. It grants at most one core access per cycle using round-robin, stalls the loser, and routes read data back to the requester. It also implements a hardware test-and-set lock at a reserved address so the cores can build critical sections around shared data.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between two cores and one single-port data memory, plus a test-and-set lock register.
// Latency: writes complete in the grant cycle; memory and lock reads return one cycle after the grant.
// Backpressure: an eligible core that loses arbitration, or whose read is in flight, sees stall=1 and holds its command.
module dmem_arbiter #(
  parameter int                   W_CPU     = 32,
  parameter int                   W_MEM_CMD = 2,
  parameter logic [W_MEM_CMD-1:0] CMD_NOP   = W_MEM_CMD'(0),
  parameter logic [W_MEM_CMD-1:0] CMD_READ  = W_MEM_CMD'(1),
  parameter logic [W_MEM_CMD-1:0] CMD_WRITE = W_MEM_CMD'(2),
  parameter logic [W_CPU-1:0]     LOCK_ADDR = W_CPU'(32'h2FFC),
  parameter int                   W_CNT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_MEM_CMD-1:0] c0_mem_cmd,
  input  logic [W_CPU-1:0]     c0_addr,
  input  logic [W_CPU-1:0]     c0_wdata,
  output logic [W_CPU-1:0]     c0_rdata,
  output logic                 c0_rvalid,
  output logic                 c0_stall,
  input  logic [W_MEM_CMD-1:0] c1_mem_cmd,
  input  logic [W_CPU-1:0]     c1_addr,
  input  logic [W_CPU-1:0]     c1_wdata,
  output logic [W_CPU-1:0]     c1_rdata,
  output logic                 c1_rvalid,
  output logic                 c1_stall,
  output logic [W_MEM_CMD-1:0] m_mem_cmd,
  output logic [W_CPU-1:0]     m_addr,
  output logic [W_CPU-1:0]     m_wdata,
  input  logic [W_CPU-1:0]     m_rdata,
  output logic                 lock_held,
  output logic                 lock_owner,
  output logic [W_CNT-1:0]     contention_cnt
);

  logic             c0_rd, c0_wr, c1_rd, c1_wr;
  logic             c0_elig, c1_elig;
  logic             c0_gnt, c1_gnt, gnt_any;
  logic             last_grant;
  logic             c0_ret, c1_ret;
  logic             c0_ret_lock, c1_ret_lock;
  logic             c0_lock_val, c1_lock_val;
  logic             gnt_rd, gnt_lock;
  logic [W_CPU-1:0] gnt_addr, gnt_wdata;

  // Unknown encodings decode as neither read nor write, i.e. as NOP.
  assign c0_rd = (c0_mem_cmd == CMD_READ);
  assign c0_wr = (c0_mem_cmd == CMD_WRITE);
  assign c1_rd = (c1_mem_cmd == CMD_READ);
  assign c1_wr = (c1_mem_cmd == CMD_WRITE);

  // A core sitting in its read-return cycle is not eligible, so its held command is not reissued.
  // Gating with reset keeps every combinational output at its idle value while reset is low.
  assign c0_elig = reset && (c0_rd || c0_wr) && !c0_ret;
  assign c1_elig = reset && (c1_rd || c1_wr) && !c1_ret;

  // On contention the core that did not win last time is granted.
  assign c0_gnt  = c0_elig && (!c1_elig || last_grant);
  assign c1_gnt  = c1_elig && !c0_gnt;
  assign gnt_any = c0_gnt || c1_gnt;

  // Granted writes finish this cycle; granted reads and losers stall.
  assign c0_stall = c0_elig && !(c0_gnt && c0_wr);
  assign c1_stall = c1_elig && !(c1_gnt && c1_wr);

  // Select the granted core's request.
  always_comb begin
    gnt_rd    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (c0_gnt) begin
      gnt_rd    = c0_rd;
      gnt_addr  = c0_addr;
      gnt_wdata = c0_wdata;
    end else if (c1_gnt) begin
      gnt_rd    = c1_rd;
      gnt_addr  = c1_addr;
      gnt_wdata = c1_wdata;
    end
  end

  assign gnt_lock = gnt_any && (gnt_addr == LOCK_ADDR);

  // Drive the memory port only for a granted non-lock access; otherwise idle with zeroed address/data.
  always_comb begin
    m_mem_cmd = CMD_NOP;
    m_addr    = '0;
    m_wdata   = '0;
    if (gnt_any && !gnt_lock) begin
      m_mem_cmd = gnt_rd ? CMD_READ : CMD_WRITE;
      m_addr    = gnt_addr;
      m_wdata   = gnt_wdata;
    end
  end

  // Read data: lock reads return the sampled lock state, memory reads pass m_rdata straight through.
  assign c0_rvalid = c0_ret;
  assign c1_rvalid = c1_ret;
  assign c0_rdata  = !c0_ret ? '0 : (c0_ret_lock ? {{(W_CPU-1){1'b0}}, c0_lock_val} : m_rdata);
  assign c1_rdata  = !c1_ret ? '0 : (c1_ret_lock ? {{(W_CPU-1){1'b0}}, c1_lock_val} : m_rdata);

  // Track the one-cycle read return for each core, including the test-and-set result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0_ret      <= 1'b0;
      c1_ret      <= 1'b0;
      c0_ret_lock <= 1'b0;
      c1_ret_lock <= 1'b0;
      c0_lock_val <= 1'b0;
      c1_lock_val <= 1'b0;
    end else begin
      c0_ret      <= c0_gnt && c0_rd;
      c1_ret      <= c1_gnt && c1_rd;
      c0_ret_lock <= c0_gnt && gnt_lock;
      c1_ret_lock <= c1_gnt && gnt_lock;
      c0_lock_val <= lock_held;
      c1_lock_val <= lock_held;
    end
  end

  // Remember which core was granted last for round-robin; core 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (c0_gnt) begin
      last_grant <= 1'b0;
    end else if (c1_gnt) begin
      last_grant <= 1'b1;
    end
  end

  // Test-and-set acquires a free lock; only the owner writing bit0=0 releases it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_held  <= 1'b0;
      lock_owner <= 1'b0;
    end else if (gnt_lock) begin
      if (gnt_rd) begin
        if (!lock_held) begin
          lock_held  <= 1'b1;
          lock_owner <= c1_gnt;
        end
      end else if (lock_held && (lock_owner == c1_gnt) && !gnt_wdata[0]) begin
        lock_held <= 1'b0;
      end
    end
  end

  // Count cycles where both cores were eligible, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contention_cnt <= '0;
    end else if (c0_elig && c1_elig && !(&contention_cnt)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule
